// File: rtl/companion_pkg.sv
`default_nettype none
// ============================================================================
// Module  : companion_pkg
// Brief   : Shared constants and enums for the companion action controller.
// Rev     : 1.0
// ============================================================================
package companion_pkg;

    localparam logic [31:0] STAT_MAX = 32'd10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FEED  = 2'd1,
        PLAY  = 2'd2,
        CLEAN = 2'd3
    } action_t;

endpackage
`default_nettype wire

// File: rtl/companion_action_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : companion_action_ctrl_if
// Brief   : Button, stat and action-pulse bundle of the companion controller.
// Rev     : 1.0
// ============================================================================
interface companion_action_ctrl_if;
    logic        btn_feed;
    logic        btn_play;
    logic        btn_clean;
    logic [31:0] hunger;
    logic [31:0] happiness;
    logic [31:0] clean;
    logic [31:0] health;
    logic        feed;
    logic        play;
    logic        clean_up;
    logic        busy;
    logic        rejected;

    modport master (
        output btn_feed, btn_play, btn_clean, hunger, happiness, clean, health,
        input  feed, play, clean_up, busy, rejected
    );

    modport slave (
        input  btn_feed, btn_play, btn_clean, hunger, happiness, clean, health,
        output feed, play, clean_up, busy, rejected
    );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Brief   : 2-flop synchronizer followed by a stable-for-N-cycles debouncer.
// Rev     : 1.0
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_250_000
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  raw,
    output logic level
);
    localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Counter tracks consecutive disagreeing cycles; any agreeing cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/companion_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : companion_action_ctrl
// Brief   : Debounced buttons -> arbitrated, stat-gated action pulses with cooldown.
// Rev     : 1.0
// ============================================================================
module companion_action_ctrl
    import companion_pkg::*;
#(
    parameter int CLOCK_FREQ      = 125_000_000,
    parameter int DEBOUNCE_CYCLES = 1_250_000,
    parameter int COOLDOWN_CYCLES = 5 * CLOCK_FREQ
) (
    input  wire         clk,
    input  wire         rst,
    input  wire         btn_feed,
    input  wire         btn_play,
    input  wire         btn_clean,
    input  wire  [31:0] hunger,
    input  wire  [31:0] happiness,
    input  wire  [31:0] clean,
    input  wire  [31:0] health,
    output logic        feed,
    output logic        play,
    output logic        clean_up,
    output logic        busy,
    output logic        rejected
);
    localparam int             CDW     = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_CYCLES - 1);

    logic           lvl_feed, lvl_play, lvl_clean;
    logic [2:0]     lvl_d;
    logic           req_feed, req_play, req_clean;
    logic           any_req, multi_req, target_full, accept, reject_nx;
    action_t        winner, action;
    state_t         state, state_nx;
    logic [CDW-1:0] cd_cnt;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_feed (
        .clk(clk), .rst(rst), .raw(btn_feed), .level(lvl_feed)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .clk(clk), .rst(rst), .raw(btn_play), .level(lvl_play)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clean (
        .clk(clk), .rst(rst), .raw(btn_clean), .level(lvl_clean)
    );

    assign req_feed  = lvl_feed  & ~lvl_d[0];
    assign req_play  = lvl_play  & ~lvl_d[1];
    assign req_clean = lvl_clean & ~lvl_d[2];

    // Fixed priority feed > clean_up > play; losers fold into one rejected pulse.
    always_comb begin
        winner      = NONE;
        target_full = 1'b0;
        if (req_feed) begin
            winner      = FEED;
            target_full = (hunger == STAT_MAX);
        end else if (req_clean) begin
            winner      = CLEAN;
            target_full = (clean == STAT_MAX);
        end else if (req_play) begin
            winner      = PLAY;
            target_full = (happiness == STAT_MAX);
        end
        any_req   = req_feed | req_play | req_clean;
        multi_req = (req_feed & req_play) | (req_feed & req_clean) | (req_play & req_clean);
        accept    = any_req && (state == IDLE) && (health != 32'd0) && !target_full;
        reject_nx = any_req && (!accept || multi_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            action   <= NONE;
            cd_cnt   <= '0;
            rejected <= 1'b0;
            lvl_d    <= 3'b000;
        end else begin
            state    <= state_nx;
            rejected <= reject_nx;
            lvl_d    <= {lvl_clean, lvl_play, lvl_feed};
            if (accept) begin
                action <= winner;
            end
            // Cleared while in FIRE so it starts at zero on entry; saturates at the end.
            if (state == FIRE) begin
                cd_cnt <= '0;
            end else if (state == COOLDOWN && cd_cnt != CD_LAST) begin
                cd_cnt <= cd_cnt + CDW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = FIRE;
            FIRE:     state_nx = COOLDOWN;
            COOLDOWN: if (cd_cnt == CD_LAST) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        feed     = (state == FIRE) && (action == FEED);
        play     = (state == FIRE) && (action == PLAY);
        clean_up = (state == FIRE) && (action == CLEAN);
        busy     = (state == FIRE) || (state == COOLDOWN);
    end
endmodule
`default_nettype wire
